// File: rtl/nx_tick_sequencer.sv
// Mesh tick controller: triggers the mesh column-wise for a programmed number of ticks,
// waits for idle under a watchdog, and streams the mesh outputs back in fixed-width sections.
module nx_tick_sequencer #(
    parameter int  COLUMNS     = 4,
    parameter int  OUTPUTS     = 32,
    parameter int  SECTION_W   = 64,
    parameter int  TIMER_WIDTH = 24,
    localparam int NUM_SECT    = (COLUMNS * OUTPUTS + SECTION_W - 1) / SECTION_W,
    localparam int IDX_W       = (NUM_SECT > 1) ? $clog2(NUM_SECT) : 1
) (
    input  logic                         i_clk,
    input  logic                         i_rst,
    input  logic                         i_req_valid,
    output logic                         o_req_ready,
    input  logic [2:0]                   i_req_cmd,
    input  logic [TIMER_WIDTH-1:0]       i_req_data,
    output logic                         o_resp_valid,
    input  logic                         i_resp_ready,
    output logic [1:0]                   o_resp_type,
    output logic [TIMER_WIDTH-1:0]       o_resp_stamp,
    output logic [IDX_W-1:0]             o_resp_index,
    output logic [SECTION_W-1:0]         o_resp_data,
    input  logic [COLUMNS-1:0]           i_mesh_node_idle,
    input  logic                         i_mesh_agg_idle,
    output logic [COLUMNS-1:0]           o_mesh_trigger,
    input  logic [COLUMNS*OUTPUTS-1:0]   i_mesh_outputs,
    output logic                         o_status_active,
    output logic                         o_status_fault
);
    localparam int PAD_W = NUM_SECT * SECTION_W;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_SECT - 1);
    localparam logic [IDX_W-1:0] ONE_I = IDX_W'(1);
    localparam logic [TIMER_WIDTH-1:0] ONE_T = TIMER_WIDTH'(1);

    localparam logic [2:0] CMD_SET_MASK    = 3'd1;
    localparam logic [2:0] CMD_START       = 3'd2;
    localparam logic [2:0] CMD_STOP        = 3'd3;
    localparam logic [2:0] CMD_SET_TIMEOUT = 3'd4;
    localparam logic [2:0] CMD_SET_MODE    = 3'd5;
    localparam logic [2:0] CMD_READ_STATUS = 3'd6;

    localparam logic [1:0] RESP_OUTPUTS = 2'd0;
    localparam logic [1:0] RESP_STATUS  = 2'd1;
    localparam logic [1:0] RESP_TIMEOUT = 2'd2;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_TRIGGER = 3'd1,
        S_WAIT    = 3'd2,
        S_OUTPUTS = 3'd3,
        S_FAULT   = 3'd4
    } state_t;

    state_t                   state_reg, state_next;
    logic [COLUMNS-1:0]       mask_reg, mask_next;
    logic [TIMER_WIDTH-1:0]   timeout_reg, timeout_next;
    logic [TIMER_WIDTH-1:0]   stamp_reg, stamp_next;
    logic [TIMER_WIDTH-1:0]   remaining_reg, remaining_next;
    logic [TIMER_WIDTH-1:0]   wait_cnt_reg, wait_cnt_next;
    logic                     delta_mode_reg, delta_mode_next;
    logic                     force_full_reg, force_full_next;
    logic                     fault_reg, fault_next;
    logic                     seen_low_reg, seen_low_next;
    logic                     status_pend_reg, status_pend_next;
    logic                     ready_reg, ready_next;
    logic                     active_reg, active_next;
    logic                     all_idle_reg;
    logic [IDX_W-1:0]         idx_reg, idx_next;
    logic [COLUMNS-1:0]       trigger_reg, trigger_next;
    logic                     resp_valid_reg, resp_valid_next;
    logic [1:0]               resp_type_reg, resp_type_next;
    logic [TIMER_WIDTH-1:0]   resp_stamp_reg, resp_stamp_next;
    logic [IDX_W-1:0]         resp_index_reg, resp_index_next;
    logic [SECTION_W-1:0]     resp_data_reg, resp_data_next;
    logic [SECTION_W-1:0]     snapshot_reg [NUM_SECT];
    logic [SECTION_W-1:0]     snapshot_next [NUM_SECT];

    logic [PAD_W-1:0]         padded;
    logic [SECTION_W-1:0]     sections [NUM_SECT];
    logic                     resp_free, accept, rem_write, start_go, status_req, fsm_emit;
    logic [1:0]               fsm_type;
    logic [IDX_W-1:0]         fsm_index;
    logic [SECTION_W-1:0]     fsm_data, status_word;

    assign padded = PAD_W'(i_mesh_outputs);

    generate
        for (genvar gi = 0; gi < NUM_SECT; gi++) begin : g_sect
            assign sections[gi] = padded[gi*SECTION_W +: SECTION_W];
        end
    endgenerate

    // Ready combines a registered state term with the live stall so a consumed response frees the port at once.
    assign resp_free   = !(resp_valid_reg && !i_resp_ready);
    assign o_req_ready = ready_reg && resp_free;
    assign accept      = i_req_valid && o_req_ready;
    assign status_word = SECTION_W'({state_reg, all_idle_reg, delta_mode_reg, fault_reg, remaining_reg});

    always_comb begin
        state_next       = state_reg;
        mask_next        = mask_reg;
        timeout_next     = timeout_reg;
        stamp_next       = stamp_reg;
        remaining_next   = remaining_reg;
        wait_cnt_next    = wait_cnt_reg;
        delta_mode_next  = delta_mode_reg;
        force_full_next  = force_full_reg;
        fault_next       = fault_reg;
        seen_low_next    = seen_low_reg;
        idx_next         = idx_reg;
        snapshot_next    = snapshot_reg;
        trigger_next     = '0;
        rem_write        = 1'b0;
        start_go         = 1'b0;
        status_req       = status_pend_reg;
        fsm_emit         = 1'b0;
        fsm_type         = RESP_OUTPUTS;
        fsm_index        = '0;
        fsm_data         = '0;

        if (accept) begin
            case (i_req_cmd)
                CMD_SET_MASK:    mask_next = COLUMNS'(i_req_data);
                CMD_SET_TIMEOUT: timeout_next = i_req_data;
                CMD_SET_MODE:    delta_mode_next = i_req_data[0];
                CMD_READ_STATUS: status_req = 1'b1;
                CMD_STOP: begin
                    remaining_next = '0;
                    rem_write      = 1'b1;
                end
                CMD_START: begin
                    if (i_req_data != '0) begin
                        remaining_next = i_req_data;
                        rem_write      = 1'b1;
                        if (state_reg == S_IDLE) begin
                            force_full_next = 1'b1;
                            fault_next      = 1'b0;
                            start_go        = 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end

        case (state_reg)
            S_IDLE: if (start_go) state_next = S_TRIGGER;
            S_TRIGGER: begin
                trigger_next  = mask_reg;
                wait_cnt_next = '0;
                seen_low_next = 1'b0;
                state_next    = S_WAIT;
                if (!rem_write && remaining_reg != '0) remaining_next = remaining_reg - ONE_T;
            end
            S_WAIT: begin
                seen_low_next = seen_low_reg || !all_idle_reg;
                if (seen_low_reg && all_idle_reg) begin
                    state_next = S_OUTPUTS;
                    idx_next   = '0;
                end else if (timeout_reg != '0 && wait_cnt_reg == timeout_reg - ONE_T) begin
                    state_next = S_FAULT;
                end else if (wait_cnt_reg != '1) begin
                    wait_cnt_next = wait_cnt_reg + ONE_T;
                end
            end
            S_OUTPUTS: begin
                if (resp_free) begin
                    // Unchanged sections still take their cycle so the walk length is fixed.
                    fsm_emit  = !(delta_mode_reg && !force_full_reg && sections[idx_reg] == snapshot_reg[idx_reg]);
                    fsm_type  = RESP_OUTPUTS;
                    fsm_index = idx_reg;
                    fsm_data  = sections[idx_reg];
                    if (idx_reg == LAST_IDX) begin
                        snapshot_next   = sections;
                        stamp_next      = stamp_reg + ONE_T;
                        force_full_next = 1'b0;
                        idx_next        = '0;
                        state_next      = (remaining_reg != '0) ? S_TRIGGER : S_IDLE;
                    end else begin
                        idx_next = idx_reg + ONE_I;
                    end
                end
            end
            S_FAULT: begin
                if (resp_free) begin
                    fsm_emit       = 1'b1;
                    fsm_type       = RESP_TIMEOUT;
                    fsm_data       = SECTION_W'(wait_cnt_reg);
                    fault_next     = 1'b1;
                    remaining_next = '0;
                    state_next     = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase

        resp_valid_next  = resp_valid_reg;
        resp_type_next   = resp_type_reg;
        resp_stamp_next  = resp_stamp_reg;
        resp_index_next  = resp_index_reg;
        resp_data_next   = resp_data_reg;
        status_pend_next = status_req;
        // A status read collides only with FSM responses; it is deferred, never dropped.
        if (resp_free) begin
            if (fsm_emit) begin
                resp_valid_next = 1'b1;
                resp_type_next  = fsm_type;
                resp_stamp_next = stamp_reg;
                resp_index_next = fsm_index;
                resp_data_next  = fsm_data;
            end else if (status_req) begin
                resp_valid_next  = 1'b1;
                resp_type_next   = RESP_STATUS;
                resp_stamp_next  = stamp_reg;
                resp_index_next  = '0;
                resp_data_next   = status_word;
                status_pend_next = 1'b0;
            end else begin
                resp_valid_next = 1'b0;
            end
        end

        ready_next  = (state_next != S_OUTPUTS);
        active_next = (state_next != S_IDLE);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_reg       <= S_IDLE;
            mask_reg        <= '1;
            timeout_reg     <= '0;
            stamp_reg       <= '0;
            remaining_reg   <= '0;
            wait_cnt_reg    <= '0;
            delta_mode_reg  <= 1'b0;
            force_full_reg  <= 1'b0;
            fault_reg       <= 1'b0;
            seen_low_reg    <= 1'b0;
            status_pend_reg <= 1'b0;
            ready_reg       <= 1'b0;
            active_reg      <= 1'b0;
            all_idle_reg    <= 1'b0;
            idx_reg         <= '0;
            trigger_reg     <= '0;
            resp_valid_reg  <= 1'b0;
            resp_type_reg   <= '0;
            resp_stamp_reg  <= '0;
            resp_index_reg  <= '0;
            resp_data_reg   <= '0;
            for (int i = 0; i < NUM_SECT; i++) snapshot_reg[i] <= '0;
        end else begin
            state_reg       <= state_next;
            mask_reg        <= mask_next;
            timeout_reg     <= timeout_next;
            stamp_reg       <= stamp_next;
            remaining_reg   <= remaining_next;
            wait_cnt_reg    <= wait_cnt_next;
            delta_mode_reg  <= delta_mode_next;
            force_full_reg  <= force_full_next;
            fault_reg       <= fault_next;
            seen_low_reg    <= seen_low_next;
            status_pend_reg <= status_pend_next;
            ready_reg       <= ready_next;
            active_reg      <= active_next;
            all_idle_reg    <= (&i_mesh_node_idle) && i_mesh_agg_idle;
            idx_reg         <= idx_next;
            trigger_reg     <= trigger_next;
            resp_valid_reg  <= resp_valid_next;
            resp_type_reg   <= resp_type_next;
            resp_stamp_reg  <= resp_stamp_next;
            resp_index_reg  <= resp_index_next;
            resp_data_reg   <= resp_data_next;
            snapshot_reg    <= snapshot_next;
        end
    end

    assign o_mesh_trigger  = trigger_reg;
    assign o_resp_valid    = resp_valid_reg;
    assign o_resp_type     = resp_type_reg;
    assign o_resp_stamp    = resp_stamp_reg;
    assign o_resp_index    = resp_index_reg;
    assign o_resp_data     = resp_data_reg;
    assign o_status_active = active_reg;
    assign o_status_fault  = fault_reg;
endmodule
